// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end feeding the decode stage.
//
// Issues sequential word-aligned fetch addresses on a request/response memory
// bus, buffers returned instructions in an in-order FIFO, and presents them
// to decode with their PC and access-fault flag over a valid/ready handshake.
// A redirect flushes the FIFO, restarts fetch at the new PC and discards every
// response still in flight for the old stream.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_redirect(_pc)      flush and restart fetch at the given PC
//   o_req_valid/addr     fetch request, accepted when i_req_ready is high
//   i_rsp_valid/data/err in-order response, no backpressure
//   o_inst_valid/inst/inst_pc/inst_fault, i_inst_ready   decode handshake
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [31:0] o_req_addr,
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_data,
    input  logic        i_rsp_err,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_fault
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] data_mem  [FIFO_DEPTH];
    logic [31:0] pc_mem    [FIFO_DEPTH];
    logic        fault_mem [FIFO_DEPTH];

    logic [CW:0] in_use;
    logic        credit_ok;
    logic        req_fire;
    logic        push;
    logic        pop;
    logic        stale_rsp;
    logic [31:0] redirect_pc_aligned;

    // Outstanding requests plus buffered entries may never exceed the FIFO
    // size, so every response is guaranteed a slot and needs no ready.
    assign in_use    = {1'b0, outstanding_q} + {1'b0, count_q};
    assign credit_ok = in_use < (CW + 1)'(FIFO_DEPTH);

    assign o_req_valid = !i_rst && !i_redirect && credit_ok;
    assign o_req_addr  = fetch_pc_q;
    assign req_fire    = o_req_valid && i_req_ready;

    assign stale_rsp = i_rsp_valid && (discard_q != '0);
    // Responses landing in the redirect cycle belong to the old stream.
    assign push      = !i_rst && i_rsp_valid && !i_redirect && (discard_q == '0);

    assign o_inst_valid = !i_rst && (count_q != '0);
    assign pop          = o_inst_valid && i_inst_ready && !i_redirect;

    assign o_inst       = o_inst_valid ? data_mem[rd_ptr_q]  : '0;
    assign o_inst_pc    = o_inst_valid ? pc_mem[rd_ptr_q]    : '0;
    assign o_inst_fault = o_inst_valid ? fault_mem[rd_ptr_q] : 1'b0;

    assign redirect_pc_aligned = i_redirect_pc & ~32'h3;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        // Request and response bookkeeping is unaffected by a redirect; no
        // request can fire in that cycle anyway.
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(i_rsp_valid);

        if (i_redirect) begin
            fetch_pc_d = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
            // Everything still in flight after this cycle is stale.
            discard_d  = outstanding_q - CW'(i_rsp_valid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (stale_rsp) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q    <= RESET_VECTOR;
            resp_pc_q     <= RESET_VECTOR;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Storage needs no reset: count_q gates everything read from it.
    always_ff @(posedge i_clk) begin
        if (push) begin
            data_mem[wr_ptr_q]  <= i_rsp_data;
            pc_mem[wr_ptr_q]    <= resp_pc_q;
            fault_mem[wr_ptr_q] <= i_rsp_err;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (outstanding_q <= CW'(FIFO_DEPTH));
            assert (discard_q <= outstanding_q);
            assert (!(i_rsp_valid && (outstanding_q == '0)));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit.
// A bus model answers accepted requests in order after a random latency.
// The reference model tracks the expected instruction stream (start PC of the
// current stream, +4 per request), occupancy and credits; a monitor pops the
// expected-stream queue whenever decode takes an instruction.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned NCYC  = 3000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_req_valid;
    logic        i_req_ready;
    logic [31:0] o_req_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        i_rsp_err;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_fault;

    fetch_unit #(
        .RESET_VECTOR (32'h8000_0000),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_req_valid   (o_req_valid),
        .i_req_ready   (i_req_ready),
        .o_req_addr    (o_req_addr),
        .i_rsp_valid   (i_rsp_valid),
        .i_rsp_data    (i_rsp_data),
        .i_rsp_err     (i_rsp_err),
        .o_inst_valid  (o_inst_valid),
        .i_inst_ready  (i_inst_ready),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc),
        .o_inst_fault  (o_inst_fault)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          stream;
    } mem_t;

    mem_t        mem_q[$];   // accepted requests awaiting a response
    logic [31:0] exp_q[$];   // current-stream PCs, oldest first
    int          n_checks = 0;
    int          n_fail   = 0;
    int          tb_occ   = 0;
    int          tb_stream = 0;
    int          last_due = 0;
    logic [31:0] model_pc = 32'h8000_0000;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Only 0x80000008 faults in the boot page; elsewhere a sparse pattern.
    function automatic logic mem_err(input logic [31:0] a);
        logic [19:0] page;
        page = a[31:12];
        return (a == 32'h8000_0008) || ((page != 20'h80000) && (a[6:2] == 5'd7));
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares decode-side outputs against the expected stream.
    initial begin
        forever begin
            @(negedge i_clk);
            #2;
            if (!i_rst) begin
                check32("inst_valid", 32'(o_inst_valid), 32'(tb_occ > 0));
                if (o_inst_valid && i_inst_ready && !i_redirect) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL pop_empty: got pc %h expected no instruction", o_inst_pc);
                    end else begin
                        logic [31:0] pc;
                        pc = exp_q.pop_front();
                        check32("inst_pc", o_inst_pc, pc);
                        check32("inst_data", o_inst, mem_data(pc));
                        check32("inst_fault", 32'(o_inst_fault), 32'(mem_err(pc)));
                    end
                end
            end
        end
    end

    // Stimulus, bus model and reference bookkeeping.
    initial begin
        logic        kept;
        logic        exp_rv;
        int          lat;
        mem_t        m;

        i_rst = 1'b1;
        i_redirect = 1'b0;
        i_redirect_pc = '0;
        i_req_ready = 1'b1;
        i_inst_ready = 1'b1;
        i_rsp_valid = 1'b0;
        i_rsp_data = '0;
        i_rsp_err = 1'b0;

        repeat (3) begin
            @(negedge i_clk);
            #1;
            check32("rst_req_valid", 32'(o_req_valid), 32'd0);
            check32("rst_inst_valid", 32'(o_inst_valid), 32'd0);
            check32("rst_inst", o_inst, 32'd0);
            check32("rst_inst_pc", o_inst_pc, 32'd0);
            check32("rst_inst_fault", 32'(o_inst_fault), 32'd0);
        end

        for (int cyc = 0; cyc < int'(NCYC); cyc++) begin
            @(negedge i_clk);
            i_rst = 1'b0;

            // Bus response, in order, once its due cycle is reached.
            kept = 1'b0;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                m = mem_q.pop_front();
                i_rsp_valid = 1'b1;
                i_rsp_data  = mem_data(m.addr);
                i_rsp_err   = mem_err(m.addr);
                kept        = (m.stream == tb_stream);
            end else begin
                i_rsp_valid = 1'b0;
                i_rsp_data  = $urandom;
                i_rsp_err   = 1'($urandom_range(0, 1));
            end

            if (cyc < 40)                      lat = 1;
            else if (cyc < 130)                lat = $urandom_range(1, 2);
            else if (cyc < 160)                lat = 4;
            else                               lat = $urandom_range(1, 4);

            if (cyc < 80 || (cyc >= 130 && cyc < 160)) i_req_ready = 1'b1;
            else if (cyc < 130)  i_req_ready = 1'($urandom_range(0, 1));
            else                 i_req_ready = ($urandom_range(0, 3) != 0);

            if (cyc < 40 || (cyc >= 60 && cyc < 80) || (cyc >= 130 && cyc < 160))
                i_inst_ready = 1'b1;
            else if (cyc < 60)   i_inst_ready = 1'b0;
            else                 i_inst_ready = ($urandom_range(0, 9) < 7);

            i_redirect_pc = $urandom;
            if (cyc == 136) begin
                i_redirect    = 1'b1;
                i_redirect_pc = 32'h8000_0103;
            end else if (cyc == 200) begin
                i_redirect    = 1'b1;
                i_redirect_pc = 32'h8000_0402;
            end else if (cyc > 220) begin
                i_redirect = ($urandom_range(0, 15) == 0);
            end else begin
                i_redirect = 1'b0;
            end
            kept = kept && !i_redirect;

            #1;
            exp_rv = !i_redirect &&
                     ((mem_q.size() + int'(i_rsp_valid) + tb_occ) < int'(DEPTH));
            check32("req_valid", 32'(o_req_valid), 32'(exp_rv));
            if (o_req_valid) check32("req_addr", o_req_addr, model_pc);
            if (o_req_valid && i_req_ready) begin
                last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                mem_q.push_back('{addr: o_req_addr, due: last_due, stream: tb_stream});
                if (!i_redirect) begin
                    exp_q.push_back(model_pc);
                    model_pc = model_pc + 32'd4;
                end
            end

            #2;
            if (i_redirect) begin
                tb_occ = 0;
                exp_q.delete();
                tb_stream++;
                model_pc = i_redirect_pc & ~32'h3;
            end else begin
                tb_occ = tb_occ + int'(kept) - int'(tb_occ > 0 && i_inst_ready);
            end
        end

        @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end, directly upstream of the core's decode stage.
- Generates sequential fetch addresses and issues them to an instruction-memory request/response bus.
- Buffers returned instructions in an in-order FIFO and presents them with their PCs to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding responses still in flight.

Parameters:
- RESET_VECTOR, 32'h80000000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2. Also bounds outstanding requests.

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  synchronous active-high reset
- i_redirect  input  1  flush and restart fetch at i_redirect_pc
- i_redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 0
- o_req_valid  output  1  fetch request valid
- i_req_ready  input  1  memory accepts request
- o_req_addr  output  32  word-aligned fetch address
- i_rsp_valid  input  1  response returned (in order, no backpressure)
- i_rsp_data  input  32  instruction word
- i_rsp_err  input  1  access fault on this response
- o_inst_valid  output  1  FIFO head valid
- i_inst_ready  input  1  decode consumes head
- o_inst  output  32  head instruction
- o_inst_pc  output  32  head PC
- o_inst_fault  output  1  head carries access fault

Behaviour:
- Reset (i_rst high at edge): fetch_pc=RESET_VECTOR, FIFO empty, outstanding=0, discard=0. During reset o_req_valid=0, o_inst_valid=0, o_inst/o_inst_pc/o_inst_fault=0.
- Definitions:
  - req_fire = o_req_valid & i_req_ready
  - pop = o_inst_valid & i_inst_ready
  - outstanding = accepted requests not yet responded, stale ones included
  - discard = stale requests still in flight
- Credit rule: o_req_valid = !i_rst & !i_redirect & (outstanding + occupancy < FIFO_DEPTH). Occupancy is the current count. The FIFO can never overflow and i_rsp_valid needs no ready.
- o_req_addr = fetch_pc. On req_fire, fetch_pc += 4 (wraps modulo 2^32).
- While o_req_valid=1 and i_req_ready=0, the address stays stable until accepted or a redirect occurs. The bus permits withdrawal on redirect.
- Response arriving with discard>0: dropped, discard decremented, outstanding decremented.
- Response arriving with discard=0: pushed with {data, err, pc}, outstanding decremented. The entry pc comes from a separate pc-tag FIFO, or equivalently resp_pc register advancing by 4 per kept response.
- Visibility: a response pushed in cycle N is visible on o_inst_valid in cycle N+1. There is no bypass.
- FIFO head outputs are combinational from storage. Push and pop in the same cycle are both honoured, including when full, since pop frees a slot.
- Redirect in cycle N, which takes priority over everything:
  - fetch_pc <= {i_redirect_pc[31:2],2'b00}; resp_pc set equal.
  - FIFO cleared; a pop in cycle N is ignored.
  - o_req_valid forced 0 in cycle N, so no request is issued to the old stream.
  - Any i_rsp_valid in cycle N is dropped.
  - discard <= outstanding − i_rsp_valid, all remaining in flight. outstanding updates normally.
  - First new-stream request is presented in cycle N+1.
- Back-to-back redirects: the last one wins. Each recomputes discard from current outstanding.
- Fault: i_rsp_err sets o_inst_fault on that entry. Fetch continues sequentially; decode handles the trap.
- Counters are $clog2(FIFO_DEPTH)+1 bits wide. Assertions: outstanding ≤ FIFO_DEPTH; discard ≤ outstanding; no i_rsp_valid when outstanding=0.

Test Plan:
- Reset release, memory always ready, 1-cycle response latency, decode always ready: requests 0x80000000, 0x80000004, 0x80000008… on consecutive cycles. Instructions emerge in order, one per cycle after 3-cycle startup, o_inst_pc matching.
- i_inst_ready=0: after 4 responses o_req_valid drops (credit exhausted) and FIFO holds 4 entries. Raising ready pops one per cycle and fetching resumes with no loss or duplicate.
- i_req_ready=0 for 3 cycles: o_req_addr is held at 0x80000004 throughout. Accepted once, then advances to 0x80000008.
- Redirect to 0x80000103 with 3 requests outstanding, 4-cycle latency: next request addr 0x80000100. The 3 old responses are dropped, and the first o_inst_valid carries pc 0x80000100.
- Redirect coincident with i_rsp_valid and a pop on a non-empty FIFO: the response is dropped and the FIFO is empty the next cycle. No old-stream instruction is ever presented.
- i_rsp_err on the response for 0x80000008: that entry shows o_inst_fault=1 and its neighbours 0. Fetch continues at 0x8000000C.
